// File: rtl/rf_pkg.sv
// rf_pkg: shared constants for the regfile_sb register file.
//   RF_DATA_W / RF_ADDR_W / RF_NUM_RD : default geometry
//   WP_ALU / WP_MEM                   : write-port indices (port 1 wins on address clash)
package rf_pkg;
  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_ADDR_W = 4;
  localparam int unsigned RF_NUM_RD = 2;

  localparam int unsigned WP_ALU = 0;
  localparam int unsigned WP_MEM = 1;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus between issue/writeback logic (master) and the register
// file (slave).
//   rd_addr/rd_data/rd_busy : NUM_RD packed read ports, port k at slice k
//   wr_en/wr_addr/wr_data   : two write ports (0 = ALU, 1 = memory), packed
//   claim_en/claim_addr     : mark a destination register busy
//   claim_err               : registered pulse, claim hit an already-busy register
interface regfile_sb_if #(
  parameter int unsigned DATA_W = rf_pkg::RF_DATA_W,
  parameter int unsigned ADDR_W = rf_pkg::RF_ADDR_W,
  parameter int unsigned NUM_RD = rf_pkg::RF_NUM_RD
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [1:0]               wr_en;
  logic [2*ADDR_W-1:0]      wr_addr;
  logic [2*DATA_W-1:0]      wr_data;
  logic                     claim_en;
  logic [ADDR_W-1:0]        claim_addr;
  logic                     claim_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy, claim_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy, claim_err
  );
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of regfile_sb.
//   addr          : register address
//   regs / busy   : stored register contents and busy vector
//   wr_* / claim_*: same-cycle write and claim (only with RF_BYPASS_EN)
//   rd_data/rd_busy: read result
// Optional feature macro: RF_BYPASS_EN (forward same-cycle write data).
module rf_read_port #(
  parameter int unsigned DATA_W    = rf_pkg::RF_DATA_W,
  parameter int unsigned ADDR_W    = rf_pkg::RF_ADDR_W,
  parameter bit          ZERO_REG0 = 1'b0
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy,
`ifdef RF_BYPASS_EN
  input  logic [1:0]           wr_en,
  input  logic [2*ADDR_W-1:0]  wr_addr,
  input  logic [2*DATA_W-1:0]  wr_data,
  input  logic                 claim_en,
  input  logic [ADDR_W-1:0]    claim_addr,
`endif
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_busy
);
  import rf_pkg::*;

  always_comb begin
    rd_data = regs[addr];
    rd_busy = busy[addr];
`ifdef RF_BYPASS_EN
    // A forwarded value is the newest one; it is only busy again if a new
    // producer claims the same register in this very cycle.
    if (wr_en[WP_MEM] && (wr_addr[WP_MEM*ADDR_W +: ADDR_W] == addr)) begin
      rd_data = wr_data[WP_MEM*DATA_W +: DATA_W];
      rd_busy = claim_en && (claim_addr == addr);
    end else if (wr_en[WP_ALU] && (wr_addr[WP_ALU*ADDR_W +: ADDR_W] == addr)) begin
      rd_data = wr_data[WP_ALU*DATA_W +: DATA_W];
      rd_busy = claim_en && (claim_addr == addr);
    end
`endif
    if (ZERO_REG0 && (addr == '0)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2**ADDR_W x DATA_W register file with a per-register busy
// scoreboard, NUM_RD read ports and two write ports (ALU, memory).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (clears data, busy, claim_err)
//   bus : regfile_sb_if slave modport (reads, writes, claims, claim_err)
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W    = RF_DATA_W,
  parameter int unsigned ADDR_W    = RF_ADDR_W,
  parameter int unsigned NUM_RD    = RF_NUM_RD,
  parameter bit          ZERO_REG0 = 1'b0
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              claim_err_q;

  logic [ADDR_W-1:0] wa [2];
  logic [DATA_W-1:0] wd [2];
  logic [1:0]        wr_act;
  logic              claim_act;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      wa[p]     = bus.wr_addr[p*ADDR_W +: ADDR_W];
      wd[p]     = bus.wr_data[p*DATA_W +: DATA_W];
      wr_act[p] = bus.wr_en[p] && !(ZERO_REG0 && (wa[p] == '0));
    end
    claim_act = bus.claim_en && !(ZERO_REG0 && (bus.claim_addr == '0));
  end

  // Update order carries the priorities: memory port after ALU port so its
  // data wins, claim after both writes so a new producer keeps busy set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy        <= '0;
      claim_err_q <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (wr_act[p]) begin
          regs[wa[p]] <= wd[p];
          busy[wa[p]] <= 1'b0;
        end
      end
      if (claim_act) busy[bus.claim_addr] <= 1'b1;
      claim_err_q <= claim_act && busy[bus.claim_addr];
    end
  end

  assign bus.claim_err = claim_err_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .ZERO_REG0 (ZERO_REG0)
    ) u_rd (
      .addr       (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .regs       (regs),
      .busy       (busy),
`ifdef RF_BYPASS_EN
      .wr_en      (bus.wr_en),
      .wr_addr    (bus.wr_addr),
      .wr_data    (bus.wr_data),
      .claim_en   (bus.claim_en),
      .claim_addr (bus.claim_addr),
`endif
      .rd_data    (bus.rd_data[k*DATA_W +: DATA_W]),
      .rd_busy    (bus.rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: two instances (ZERO_REG0 = 0 and 1) share one
// stimulus stream; a behavioural model of the register file predicts every
// read port and claim_err on each falling edge, and directed steps pin the
// model with hand-computed values.
module tb_regfile_sb;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr = '0;
  logic [1:0]       wr_en = '0;
  logic [2*AW-1:0]  wr_addr = '0;
  logic [2*DW-1:0]  wr_data = '0;
  logic             claim_en = 1'b0;
  logic [AW-1:0]    claim_addr = '0;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_a ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_z ();

  assign bus_a.rd_addr = rd_addr;    assign bus_z.rd_addr = rd_addr;
  assign bus_a.wr_en = wr_en;        assign bus_z.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr;    assign bus_z.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data;    assign bus_z.wr_data = wr_data;
  assign bus_a.claim_en = claim_en;  assign bus_z.claim_en = claim_en;
  assign bus_a.claim_addr = claim_addr; assign bus_z.claim_addr = claim_addr;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG0(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG0(1'b1)) dut_z (
    .clk(clk), .rst(rst), .bus(bus_z.slave));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index z: 0 = plain, 1 = zero reg 0)
  logic [DW-1:0] m_regs [2][DEPTH];
  logic          m_busy [2][DEPTH];
  logic          m_err  [2];

  function automatic bit dropped(int z, logic [AW-1:0] a);
    return (z == 1) && (a == '0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int z = 0; z < 2; z++) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_regs[z][i] <= '0;
          m_busy[z][i] <= 1'b0;
        end
        m_err[z] <= 1'b0;
      end
    end else begin
      for (int z = 0; z < 2; z++) begin
        for (int p = 0; p < 2; p++) begin
          if (wr_en[p] && !dropped(z, wr_addr[p*AW +: AW])) begin
            m_regs[z][wr_addr[p*AW +: AW]] <= wr_data[p*DW +: DW];
            m_busy[z][wr_addr[p*AW +: AW]] <= 1'b0;
          end
        end
        if (claim_en && !dropped(z, claim_addr)) m_busy[z][claim_addr] <= 1'b1;
        m_err[z] <= claim_en && !dropped(z, claim_addr) && m_busy[z][claim_addr];
      end
    end
  end

  function automatic logic [DW-1:0] exp_data(int z, logic [AW-1:0] a);
    if (dropped(z, a)) return '0;
`ifdef RF_BYPASS_EN
    if (wr_en[1] && wr_addr[AW +: AW] == a) return wr_data[DW +: DW];
    if (wr_en[0] && wr_addr[0 +: AW] == a) return wr_data[0 +: DW];
`endif
    return m_regs[z][a];
  endfunction

  function automatic logic exp_busy(int z, logic [AW-1:0] a);
    if (dropped(z, a)) return 1'b0;
`ifdef RF_BYPASS_EN
    if ((wr_en[1] && wr_addr[AW +: AW] == a) || (wr_en[0] && wr_addr[0 +: AW] == a))
      return claim_en && (claim_addr == a);
`endif
    return m_busy[z][a];
  endfunction

  // ---------------- per-cycle comparison
  always @(negedge clk) begin
    for (int z = 0; z < 2; z++) begin
      logic [NR*DW-1:0] d;
      logic [NR-1:0]    b;
      logic             e;
      d = (z == 0) ? bus_a.rd_data : bus_z.rd_data;
      b = (z == 0) ? bus_a.rd_busy : bus_z.rd_busy;
      e = (z == 0) ? bus_a.claim_err : bus_z.claim_err;
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("model_rd_data[%0d][%0d]", z, k), 32'(d[k*DW +: DW]),
            32'(exp_data(z, rd_addr[k*AW +: AW])));
        chk($sformatf("model_rd_busy[%0d][%0d]", z, k), 32'(b[k]),
            32'(exp_busy(z, rd_addr[k*AW +: AW])));
      end
      chk($sformatf("model_claim_err[%0d]", z), 32'(e), 32'(m_err[z]));
    end
  end

  // ---------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
    wr_en = '0;
    claim_en = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset contents on every address, both ports
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      rd_addr = {4'(15 - i), 4'(i)};
      #2;
      chk("reset_rd_data", 32'(bus_a.rd_data), 32'h0);
      chk("reset_rd_busy", 32'(bus_a.rd_busy), 32'h0);
    end

    // reg i = i*4+5 via ALU port
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      set_wr(0, 4'(i), 16'(i * 4 + 5));
    end
    cyc();
    rd_addr = {4'd15, 4'd7};
    #2;
    chk("reg7", 32'(bus_a.rd_data[15:0]), 32'h0021);
    chk("reg15", 32'(bus_a.rd_data[31:16]), 32'h0041);
    cyc();
    rd_addr = {4'd2, 4'd0};
    #2;
    chk("reg0_plain", 32'(bus_a.rd_data[15:0]), 32'h0005);
    chk("reg0_zero", 32'(bus_z.rd_data[15:0]), 32'h0000);

    // claim reg 3, then ALU writeback releases it
    cyc();
    claim_en = 1'b1; claim_addr = 4'd3;
    cyc();
    rd_addr = {4'd0, 4'd3};
    #2;
    chk("claim3_busy", 32'(bus_a.rd_busy[0]), 32'h1);
    set_wr(0, 4'd3, 16'h1234);
    cyc();
    #2;
    chk("wb3_busy", 32'(bus_a.rd_busy[0]), 32'h0);
    chk("wb3_data", 32'(bus_a.rd_data[15:0]), 32'h1234);

    // both write ports on reg 9: memory port wins
    cyc();
    set_wr(0, 4'd9, 16'hAAAA);
    set_wr(1, 4'd9, 16'h5555);
    cyc();
    rd_addr = {4'd0, 4'd9};
    #2;
    chk("dual_wr9", 32'(bus_a.rd_data[15:0]), 32'h5555);

    // claim + write same register: data lands, busy stays
    cyc();
    set_wr(0, 4'd4, 16'h0777);
    claim_en = 1'b1; claim_addr = 4'd4;
    cyc();
    rd_addr = {4'd0, 4'd4};
    #2;
    chk("clmwr4_data", 32'(bus_a.rd_data[15:0]), 32'h0777);
    chk("clmwr4_busy", 32'(bus_a.rd_busy[0]), 32'h1);

    // double claim on reg 6
    cyc();
    claim_en = 1'b1; claim_addr = 4'd6;
    cyc();
    claim_en = 1'b1; claim_addr = 4'd6;
    #2;
    chk("claim6_err_first", 32'(bus_a.claim_err), 32'h0);
    cyc();
    #2;
    chk("claim6_err_second", 32'(bus_a.claim_err), 32'h1);
    cyc();
    #2;
    chk("claim6_err_drop", 32'(bus_a.claim_err), 32'h0);

    // double claim on reg 0: error only where reg 0 is real
    cyc();
    claim_en = 1'b1; claim_addr = 4'd0;
    cyc();
    claim_en = 1'b1; claim_addr = 4'd0;
    cyc();
    #2;
    chk("claim0_err_plain", 32'(bus_a.claim_err), 32'h1);
    chk("claim0_err_zero", 32'(bus_z.claim_err), 32'h0);

    // write 0xFFFF to reg 0
    cyc();
    set_wr(0, 4'd0, 16'hFFFF);
    cyc();
    rd_addr = {4'd0, 4'd0};
    #2;
    chk("wr0_zero", 32'(bus_z.rd_data[15:0]), 32'h0000);
    chk("wr0_zero_busy", 32'(bus_z.rd_busy[0]), 32'h0);
    chk("wr0_plain", 32'(bus_a.rd_data[15:0]), 32'hFFFF);

    // same-cycle write/read of reg 2
    cyc();
    rd_addr = {4'd0, 4'd2};
    set_wr(0, 4'd2, 16'hBEEF);
    #2;
`ifdef RF_BYPASS_EN
    chk("bypass_reg2", 32'(bus_a.rd_data[15:0]), 32'hBEEF);
`else
    chk("nobypass_reg2", 32'(bus_a.rd_data[15:0]), 32'h000D);
`endif
    chk("reg2_busy", 32'(bus_a.rd_busy[0]), 32'h0);

    // randomized traffic, biased to few registers for collisions
    for (int n = 0; n < 400; n++) begin
      cyc();
      if (n >= 200 && n < 203) rst = 1'b1;
      else rst = 1'b0;
      wr_en      = 2'($urandom_range(0, 3));
      wr_addr    = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      wr_data    = {16'($urandom), 16'($urandom)};
      claim_en   = 1'($urandom_range(0, 1));
      claim_addr = 4'($urandom_range(0, 7));
      rd_addr    = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      if (n == 150) begin
        // asynchronous reset mid-burst clears everything immediately
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data_a", 32'(bus_a.rd_data), 32'h0);
        chk("async_rst_busy_a", 32'(bus_a.rd_busy), 32'h0);
        chk("async_rst_err_a", 32'(bus_a.claim_err), 32'h0);
        chk("async_rst_data_z", 32'(bus_z.rd_data), 32'h0);
      end
    end
    cyc();
    rst = 1'b0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
